serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial add controller: sequences one shared full_adder cell over WIDTH cycles, LSB first.
//  Carry is registered between bit steps.
//  Trades area for latency and sits between a host register file and the result register.
//  Start/busy/done handshake; result held until the next accepted start.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  operand_A  in   WIDTH  addend A, captured on accepted start
//  operand_B  in   WIDTH  addend B, captured on accepted start
//  carry_in   in   1      initial carry, captured on accepted start
//  busy       out  1      high from the cycle after accept through the DONE cycle
//  done       out  1      one-cycle pulse: result_S/result_C valid
//  result_S   out  WIDTH  sum, stable from done until the next accepted start
//  result_C   out  1      final carry-out, same validity as result_S
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, result_S=0, result_C=0; bit counter=0; carry reg=0.
//  - FSM states:
//    - IDLE: start=1 loads shift_A<=operand_A, shift_B<=operand_B, carry reg<=carry_in, count<=0 -> SHIFT.
//    - SHIFT: full_adder inputs are shift_A[0], shift_B[0] and the carry reg.
//      Each cycle: sum bit enters result shift reg at MSB, result shifts right.
//      A and B shift right by one; carry reg<=cell carry; count++.
//      When count==WIDTH-1 -> DONE.
//    - DONE: done=1 for exactly one cycle; result_C<=carry reg -> IDLE.
//  - Latency: start sampled at edge t; done high in the cycle after edge t+WIDTH+1.
//    Back-to-back start accepted the cycle after DONE (throughput WIDTH+2 cycles/op).
//  - start in SHIFT or DONE is ignored; no queueing.
//  - Operand inputs are don't-care except on the accepted start edge.
//  - Arithmetic is modulo 2^WIDTH; carry-out goes to result_C only; no sign interpretation.
//  - Counter width: $clog2(WIDTH); no wrap because SHIFT exits at WIDTH-1.
//  - Reset mid-operation (any state): abort, go to IDLE, clear all outputs next cycle.
//    No done pulse is produced.
//  - result_S is not updated in place during SHIFT: the result shift reg is internal.
//    result_S/result_C are copied in DONE, so outputs never show partial sums.
// CONFIGURATION
//  SERIAL_SUBTRACT_EN defined:
//    - Adds input port `sub` (1 bit), captured on accepted start.
//    - sub=1: B is bit-inverted as it enters the cell; the captured carry is forced to 1 (carry_in ignored).
//      Gives A-B mod 2^WIDTH; result_C=1 means no borrow.
//  SERIAL_SUBTRACT_EN undefined: no `sub` port; add only; carry_in always used.
// STRUCTURE
//  - Shared include serial_adder_defs.vh: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
//    default width constant SA_WIDTH_DEF=8.
//  - One sub-module: the existing full_adder cell, single instance, purely combinational.
//  - Controller FSM, counter and shift registers stay in this module.
// TESTING
//  1. WIDTH=8, A=0x3C, B=0x0F, cin=0 -> result_S=0x4B, result_C=0; done exactly 10 cycles after start edge.
//  2. A=0xFF, B=0x01, cin=0 -> result_S=0x00, result_C=1; busy high 9 cycles, done 1 cycle.
//  3. A=0x00, B=0x00, cin=1 -> 0x01, C=0.
//     Then start again while busy with A=0xAA -> ignored; result still 0x01.
//  4. Reset asserted at 4th SHIFT cycle of A=0x55+B=0x55 -> next cycle busy=0, done=0, result_S=0x00.
//     No done pulse; new op A=0x01+B=0x01 then yields 0x02.
//  5. Back-to-back: start held high continuously -> ops accepted every 10 cycles; each done pulse 1 cycle wide.
//  6. SERIAL_SUBTRACT_EN, sub=1: A=0x05, B=0x07 -> result_S=0xFE, result_C=0.
//     A=0x07, B=0x05 -> 0x02, C=1.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Replaces the state encodings and default width from serial_adder_defs.vh.
package serial_adder_ctrl_pkg;

    localparam int unsigned SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell shared by the serial add controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full_adder stepped LSB-first over WIDTH cycles.
// Optional SERIAL_SUBTRACT_EN adds a `sub` port for A-B via inverted B and forced carry.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic             carry_in,
`ifdef SERIAL_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_S,
    output logic             result_C
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] shift_s;
    logic [CW-1:0]    count;
    logic             carry_r;
    logic             cell_b;
    logic             cell_s;
    logic             cell_c;
    logic             last_bit;
    logic             load_carry;

`ifdef SERIAL_SUBTRACT_EN
    logic sub_r;
    assign cell_b     = shift_b[0] ^ sub_r;
    assign load_carry = sub | carry_in;
`else
    assign cell_b     = shift_b[0];
    assign load_carry = carry_in;
`endif

    assign last_bit = (count == CW'(WIDTH - 1));

    full_adder u_cell (
        .a    (shift_a[0]),
        .b    (cell_b),
        .cin  (carry_r),
        .s    (cell_s),
        .cout (cell_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    // done and the result copy are registered off the DONE state, so the pulse
    // lands one cycle after DONE and partial sums never reach the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_a  <= '0;
            shift_b  <= '0;
            shift_s  <= '0;
            count    <= '0;
            carry_r  <= 1'b0;
            done     <= 1'b0;
            result_S <= '0;
            result_C <= 1'b0;
`ifdef SERIAL_SUBTRACT_EN
            sub_r    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_a <= operand_A;
                        shift_b <= operand_B;
                        carry_r <= load_carry;
                        count   <= '0;
`ifdef SERIAL_SUBTRACT_EN
                        sub_r   <= sub;
`endif
                    end
                end
                ST_SHIFT: begin
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    shift_s <= {cell_s, shift_s[WIDTH-1:1]};
                    carry_r <= cell_c;
                    if (!last_bit) count <= count + CW'(1);
                end
                ST_DONE: begin
                    result_S <= shift_s;
                    result_C <= carry_r;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
